cordic_dot_sequencer: RTL
=========================

CORDIC_DOT_SEQUENCER -- requirements
Module: cordic_dot_sequencer

Interface
REQ-001 Parameter N_TERMS, 8: maximum operand pairs per dot product (1..255).
REQ-002 Parameter ACC_W, 24: accumulator/result width, signed (16..32).
REQ-003 Parameter TIMEOUT, 64: maximum cycles waited for mul_done per product (4..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  block accepts operand pair this cycle.
REQ-008 in_x  input  8  signed multiplicand.
REQ-009 in_z  input  8  signed multiplier.
REQ-010 in_last  input  1  pair is the final term of the current vector.
REQ-011 mul_start  output  1  one-cycle start pulse to the CORDIC multiplier.
REQ-012 mul_x  output  8  signed operand to the multiplier, held stable from ISSUE through end of WAIT.
REQ-013 mul_z  output  8  signed operand to the multiplier, same stability as mul_x.
REQ-014 mul_y  input  16  multiplier product, interpreted as signed.
REQ-015 mul_done  input  1  multiplier result valid.
REQ-016 out_valid  output  1  dot-product result available.
REQ-017 out_ready  input  1  consumer accepts result.
REQ-018 out_acc  output  ACC_W  signed accumulated sum.
REQ-019 out_count  output  8  number of terms accumulated.
REQ-020 out_err  output  1  at least one product of this vector timed out.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, ACC, OUT.
REQ-022 IDLE: in_ready=1; on in_valid&in_ready, latch in_x/in_z/in_last, go to ISSUE; in_ready=0 in all other states.
REQ-023 ISSUE: mul_start=1 for exactly one cycle, drive latched operands, clear wait timer, go to WAIT.
REQ-024 WAIT: timer increments each cycle; mul_done ignored in first WAIT cycle (stale done from prior operation); on mul_done=1 from second WAIT cycle on, capture sign-extended mul_y, go to ACC.
REQ-025 WAIT: if timer reaches TIMEOUT without qualifying mul_done, set sticky err flag, capture product 0, go to ACC.
REQ-026 ACC: acc <= sat(acc + product), count <= count+1; go to OUT if latched last=1 or new count==N_TERMS, else IDLE.
REQ-027 Addition SHALL saturate at signed ACC_W limits (+2^(ACC_W-1)-1 / -2^(ACC_W-1)), never wrap.
REQ-028 OUT: out_valid=1 with out_acc/out_count/out_err stable; hold until out_ready=1; on handshake clear acc, count, err, go to IDLE.
REQ-029 out_acc/out_count/out_err SHALL reflect internal registers continuously; only valid when out_valid=1.
REQ-030 mul_start SHALL never assert outside ISSUE; at most one multiplication outstanding.
REQ-031 Latency, accepted pair to ACC: 2 + W cycles, W = WAIT cycles (>=2); minimum per-term period 5 cycles incl. IDLE.
REQ-032 mul_done high while not in WAIT SHALL be ignored.
REQ-033 in_valid while in_ready=0 SHALL be ignored; upstream holds data until accepted.

Reset
REQ-034 rst_n=0 at rising edge: state IDLE, acc=0, count=0, err=0, timer=0, latched operands=0.
REQ-035 During/after reset cycle: mul_start=0, mul_x=0, mul_z=0, out_valid=0, out_acc=0, out_count=0, out_err=0, in_ready=0 while rst_n=0, 1 from first cycle after release.
REQ-036 Reset in any state (incl. WAIT/OUT) SHALL abort the vector; late mul_done afterwards is ignored.

Verification (bench multiplier model: exact product, mul_done 3 cycles after start, held 1 cycle)
REQ-037 N_TERMS=4, pairs (3,4),(-5,6),(127,127),(-128,-128), in_last=0 -> out_acc=32495, out_count=4, out_err=0.
REQ-038 Pairs (10,10),(-2,50) with in_last on second -> out_acc=0, out_count=2, out_err=0.
REQ-039 Model never asserts mul_done, one pair with in_last -> mul_start once, out_valid after TIMEOUT+3 cycles, out_acc=0, out_count=1, out_err=1.
REQ-040 out_ready=0 for 10 cycles in OUT -> out_valid held, out_acc stable, in_ready=0, mul_start=0; result accepted on first out_ready=1.
REQ-041 ACC_W=16, three pairs (127,127) last on third -> out_acc=32767 (saturated), out_count=3.
REQ-042 rst_n=0 for one cycle during WAIT -> next cycle all outputs 0, state IDLE; model's subsequent mul_done causes no accumulation; new vector (2,3) last -> out_acc=6.

Source files
------------

// File: rtl/cordic_dot_sequencer.sv
// Sequencer that feeds operand pairs to an external CORDIC multiplier one
// at a time and accumulates the products into a saturating dot product.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready               operand pair handshake
//   in_x, in_z                      signed 8-bit operands
//   in_last                         pair closes the current vector
//   mul_start, mul_x, mul_z         multiplier launch pulse and operands
//   mul_y, mul_done                 multiplier product and completion
//   out_valid/out_ready             result handshake
//   out_acc, out_count, out_err     sum, term count, timeout flag
module cordic_dot_sequencer #(
   parameter int N_TERMS = 8,
   parameter int ACC_W   = 24,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_x,
   input  logic [7:0]       in_z,
   input  logic             in_last,
   output logic             mul_start,
   output logic [7:0]       mul_x,
   output logic [7:0]       mul_z,
   input  logic [15:0]      mul_y,
   input  logic             mul_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [7:0]       out_count,
   output logic             out_err
);

   localparam int SW = ACC_W + 1;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [7:0] N_MAX    = 8'(N_TERMS);
   localparam logic signed [ACC_W-1:0] ACC_MAX =
      {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN =
      {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACC,
      OUT
   } state_t;

   state_t state;
   state_t state_nx;

   logic [7:0]              x_q;
   logic [7:0]              z_q;
   logic                    last_q;
   logic [7:0]              timer;
   logic signed [ACC_W-1:0] prod;
   logic signed [ACC_W-1:0] acc;
   logic [7:0]              count;
   logic                    err;

   logic                    done_ok;
   logic                    tmo;
   logic [7:0]              count_nx;
   logic                    last_term;
   logic signed [SW-1:0]    sum;
   logic signed [ACC_W-1:0] acc_sat;

   // The first WAIT cycle has timer==0; a done seen then belongs to an
   // earlier operation and must not be taken as this product.
   assign done_ok   = mul_done && (timer != 8'd0);
   assign tmo       = (timer == TMO_LAST);
   assign count_nx  = count + 8'd1;
   assign last_term = last_q || (count_nx == N_MAX);

   // One extra bit catches overflow; clamp instead of wrapping.
   assign sum = SW'(acc) + SW'(prod);

   always_comb begin
      acc_sat = sum[ACC_W-1:0];
      if (sum[ACC_W] != sum[ACC_W-1]) begin
         acc_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      mul_start = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid) begin
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            mul_start = rst_n;
            state_nx  = WAIT;
         end
         WAIT: begin
            if (done_ok || tmo) begin
               state_nx = ACC;
            end
         end
         ACC: begin
            state_nx = last_term ? OUT : IDLE;
         end
         OUT: begin
            out_valid = rst_n;
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q    <= '0;
         z_q    <= '0;
         last_q <= 1'b0;
         timer  <= '0;
         prod   <= '0;
         acc    <= '0;
         count  <= '0;
         err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  x_q    <= in_x;
                  z_q    <= in_z;
                  last_q <= in_last;
               end
            end
            ISSUE: begin
               timer <= '0;
            end
            WAIT: begin
               timer <= timer + 8'd1;
               if (done_ok) begin
                  prod <= ACC_W'($signed(mul_y));
               end else if (tmo) begin
                  prod <= '0;
                  err  <= 1'b1;
               end
            end
            ACC: begin
               acc   <= acc_sat;
               count <= count_nx;
            end
            OUT: begin
               if (out_ready) begin
                  acc   <= '0;
                  count <= '0;
                  err   <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mul_x     = rst_n ? x_q : '0;
   assign mul_z     = rst_n ? z_q : '0;
   assign out_acc   = rst_n ? acc : '0;
   assign out_count = rst_n ? count : '0;
   assign out_err   = rst_n && err;

endmodule
